// File: rtl/norm_shift64_if.sv
// norm_shift64_if: valid/ready stream bundle around the left-shift normalizer.
//   in_valid/in_ready   : upstream handshake from the leading-zero-counter stage
//   in_data/in_lz/in_exp: unnormalized magnitude, its leading-zero count, biased exponent
//   out_valid/out_ready : downstream handshake to the rounding/packing stage
//   out_data/out_exp    : normalized magnitude and adjusted exponent
//   out_zero/out_uflow  : all-zero input / exponent could not absorb the full shift
//   master: producer + consumer side (drives in_*, out_ready); slave: the normalizer
interface norm_shift64_if #(
    parameter int EXP_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [7:0]       in_lz;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_uflow;

    modport master (
        output in_valid, in_data, in_lz, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_data, in_lz, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_zero, out_uflow
    );
endinterface

// File: rtl/norm_shift64.sv
// norm_shift64: two-stage pipelined left-shift normalizer with valid/ready on both sides.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset, clears both stages
//   bus   : norm_shift64_if.slave carrying the input beat, the output beat and both handshakes
module norm_shift64 #(
    parameter int EXP_W = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    norm_shift64_if.slave bus
);
    logic [5:0]       lz;
    logic             nz;
    logic             uf;
    logic [5:0]       sh;
    logic             s1_en;
    logic             s2_en;
    logic             unused_lz;
    logic             s1_valid_q;
    logic [63:0]      s1_data_q;
    logic [63:0]      s1_data_d;
    logic [3:0]       s1_fine_q;
    logic [3:0]       s1_fine_d;
    logic [EXP_W-1:0] s1_exp_q;
    logic [EXP_W-1:0] s1_exp_d;
    logic             s1_zero_q;
    logic             s1_uflow_q;
    logic             s2_valid_q;
    logic [63:0]      s2_data_q;
    logic [63:0]      s2_data_d;
    logic [EXP_W-1:0] s2_exp_q;
    logic             s2_zero_q;
    logic             s2_uflow_q;

    always_comb begin
        lz        = bus.in_lz[5:0];
        unused_lz = ^bus.in_lz[7:6];
        nz        = |bus.in_data;
        uf        = nz && (bus.in_exp < EXP_W'(lz));
        // on underflow in_exp < 64, so its low six bits are the whole exponent
        sh        = !nz ? 6'd0 : uf ? bus.in_exp[5:0] : lz;
        s1_data_d = bus.in_data << {sh[5:4], 4'b0000};
        s1_fine_d = sh[3:0];
        s1_exp_d  = nz ? bus.in_exp - EXP_W'(sh) : '0;
        s2_data_d = s1_data_q << s1_fine_q;
        s2_en     = !s2_valid_q || bus.out_ready;
        s1_en     = !s1_valid_q || s2_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_fine_q  <= '0;
            s1_exp_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_uflow_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_exp_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_uflow_q <= 1'b0;
        end else begin
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s2_data_d;
                s2_exp_q   <= s1_exp_q;
                s2_zero_q  <= s1_zero_q;
                s2_uflow_q <= s1_uflow_q;
            end
            if (s1_en) begin
                s1_valid_q <= bus.in_valid;
                s1_data_q  <= s1_data_d;
                s1_fine_q  <= s1_fine_d;
                s1_exp_q   <= s1_exp_d;
                s1_zero_q  <= !nz;
                s1_uflow_q <= uf;
            end
        end
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_uflow = s2_uflow_q;
endmodule

// File: tb/tb_norm_shift64.sv
// tb_norm_shift64: directed and random self-checking bench for norm_shift64.
module tb_norm_shift64;
    localparam int EXP_W = 11;

    typedef struct packed {
        logic [63:0]      d;
        logic [EXP_W-1:0] e;
        logic             z;
        logic             u;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   cyc = 0;
    res_t q[$];

    norm_shift64_if #(.EXP_W(EXP_W)) bus ();

    norm_shift64 #(.EXP_W(EXP_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic int clz(input logic [63:0] d);
        for (int i = 63; i >= 0; i--) if (d[i]) return 63 - i;
        return 0;
    endfunction

    function automatic res_t model(input logic [63:0] d, input logic [7:0] l, input logic [EXP_W-1:0] e);
        res_t r;
        logic [EXP_W-1:0] lz;
        lz = EXP_W'(l[5:0]);
        r = '0;
        if (d == 0) r.z = 1'b1;
        else if (e >= lz) begin
            r.d = d << lz;
            r.e = e - lz;
        end else begin
            r.d = d << e;
            r.u = 1'b1;
        end
        return r;
    endfunction

    // scoreboard: every presented beat is compared to the oldest expected result,
    // which also proves the outputs hold steady while stalled
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (q.size() == 0) check("spurious_out", 64'(q.size()), 64'd1);
                else begin
                    check("sb_data", bus.out_data, q[0].d);
                    check("sb_exp", 64'(bus.out_exp), 64'(q[0].e));
                    check("sb_zero", 64'(bus.out_zero), 64'(q[0].z));
                    check("sb_uflow", 64'(bus.out_uflow), 64'(q[0].u));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_data, bus.in_lz, bus.in_exp));
        end
    end

    // called #1 after a rising edge; returns #1 after the edge that accepted the beat
    task automatic send(input logic [63:0] d, input logic [7:0] l, input logic [EXP_W-1:0] e);
        int t;
        t = 0;
        bus.in_data  = d;
        bus.in_lz    = l;
        bus.in_exp   = e;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_expect(input string tag, input logic [63:0] d, input logic [7:0] l,
                               input logic [EXP_W-1:0] e, input logic [63:0] xd,
                               input logic [EXP_W-1:0] xe, input logic xz, input logic xu);
        send(d, l, e);
        @(negedge clk);
        check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, bus.out_data, xd);
        check({tag, "_exp"}, 64'(bus.out_exp), 64'(xe));
        check({tag, "_zero"}, 64'(bus.out_zero), 64'(xz));
        check({tag, "_uflow"}, 64'(bus.out_uflow), 64'(xu));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_data"}, bus.out_data, 64'd0);
        check({tag, "_exp"}, 64'(bus.out_exp), 64'd0);
        check({tag, "_zero"}, 64'(bus.out_zero), 64'd0);
        check({tag, "_uflow"}, 64'(bus.out_uflow), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (t >= 50) check("drain_timeout", 64'(q.size()), 64'd0);
        #1;
    endtask

    initial begin
        logic [63:0] bp_d[6];
        logic [63:0] d;
        logic [EXP_W-1:0] e;
        int base;
        int c0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_lz     = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        send_expect("basic", 64'h0000_0000_0001_0000, 8'd47, 11'd100, 64'h8000_0000_0000_0000, 11'd53, 1'b0, 1'b0);
        send_expect("lz_hi_ignored", 64'h0000_0000_0001_0000, 8'hEF, 11'd100, 64'h8000_0000_0000_0000, 11'd53, 1'b0, 1'b0);
        send_expect("uflow", 64'h1, 8'd63, 11'd10, 64'h400, 11'd0, 1'b0, 1'b1);
        send_expect("zero", 64'h0, 8'd0, 11'd500, 64'h0, 11'd0, 1'b1, 1'b0);
        send_expect("noshift", 64'hC000_0000_0000_0000, 8'd0, 11'd7, 64'hC000_0000_0000_0000, 11'd7, 1'b0, 1'b0);
        send_expect("exact_fit", 64'h1, 8'd63, 11'd63, 64'h8000_0000_0000_0000, 11'd0, 1'b0, 1'b0);
        send_expect("fine_only", 64'h0123_4567_89AB_CDEF, 8'd7, 11'd2047, 64'h91A2_B3C4_D5E6_F780, 11'd2040, 1'b0, 1'b0);

        // backpressure: out_ready low from the second cycle for five cycles
        bp_d = '{64'h0000_0000_0000_0001, 64'h0000_00F0_0000_0000, 64'h0, 64'h8000_0000_0000_0001,
                 64'h0000_0000_0003_0000, 64'h0000_0000_0000_00FF};
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp_d[i], 8'(clz(bp_d[i])), EXP_W'(20 + 10 * i));
            end
            begin
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_full_out_valid", 64'(bus.out_valid), 64'd1);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_out - base), 64'd6);

        // full-rate random stream
        base = n_out;
        c0 = cyc;
        for (int i = 0; i < 100; i++) begin
            d = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if ($urandom_range(0, 19) == 0) d = '0;
            e = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 70)) : EXP_W'($urandom_range(0, 2047));
            send(d, {2'($urandom_range(0, 3)), 6'(clz(d))}, e);
        end
        check("stream_cycles", 64'(cyc - c0), 64'd100);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stream_count", 64'(n_out - base), 64'd100);

        // reset with both stages full
        bus.out_ready = 1'b0;
        send(64'h0000_0000_0000_0F00, 8'd52, 11'd300);
        send(64'h0000_0000_0001_0000, 8'd47, 11'd5);
        @(negedge clk);
        check("pre_reset_full", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk);
        #1;
        send_expect("post_reset", 64'h0000_0000_0000_0F00, 8'd52, 11'd300, 64'hF000_0000_0000_0000, 11'd248, 1'b0, 1'b0);

        drain();
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/norm_shift64.md
# norm_shift64

Two-stage pipelined left-shift normalizer that consumes a 64-bit magnitude and its leading-zero count from the Normalizer leading-zero-counter stage. It outputs the normalized magnitude (MSB at bit 63), the adjusted exponent and status flags. A valid/ready handshake on both sides allows stalling by the rounding/packing stage downstream.

## Interface
- EXP_W, 11, exponent width in bits (minimum 7).
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  64  unnormalized magnitude.
- in_lz  in  8  leading-zero count of in_data from the LZC stage; only bits [5:0] are used, bits [7:6] ignored.
- in_exp  in  EXP_W  unsigned biased exponent belonging to in_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  64  normalized magnitude.
- out_exp  out  EXP_W  adjusted exponent.
- out_zero  out  1  in_data was all-zero.
- out_uflow  out  1  exponent could not absorb the full shift; result is denormal.

## Operation
- Transfer occurs on a side when valid && ready are both high at a rising edge.
- Zero detect: the LZC stage reports 0 for an all-zero input, so the block detects zero from in_data itself. For zero: out_data = 0, out_exp = 0, out_zero = 1, out_uflow = 0.
- Shift amount: sh = (in_exp >= lz) ? lz : in_exp[5:0], where lz = in_lz[5:0]. Compare at full EXP_W width with lz zero-extended.
- out_uflow = 1 when in_exp < lz and the input is nonzero.
- out_exp = in_exp - sh. This can never go negative, and equals 0 when out_uflow = 1.
- Stage 1 (S1) registers the input beat plus zero/uflow flags. It applies the coarse shift by sh[5:4]: 0, 16, 32 or 48 bits. It also computes the exponent difference.
- Stage 2 (S2) applies the fine shift by sh[3:0] and holds the registered outputs.
- Left shifts fill with zeros. Bits shifted past bit 63 are always zero by construction when in_lz is correct. The block does not check in_lz against in_data.
- Pipeline control:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
- S2 loads S1 when s2_en is high. s2_valid takes s1_valid at that point.
- S1 loads the input when s1_en is high. s1_valid takes in_valid at that point.
- A stalled stage holds all of its data stable.
- out_valid = s2_valid. Outputs come directly from S2 registers with no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready. This path is accepted.

## Timing
- Reset (rst_n low at a rising edge): s1_valid = s2_valid = 0 and all data registers cleared. Resulting outputs are out_valid = 0, out_data = 0, out_exp = 0, out_zero = 0, out_uflow = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats with no partial output. Reset takes priority over any handshake in the same cycle.
- Latency is 2 cycles: a beat accepted at edge N appears with out_valid = 1 after edge N+1, i.e. it is presentable during cycle N+2.
- Throughput is 1 beat/cycle with out_ready held high.
- Capacity is 2 beats. With out_ready low, two beats are accepted, then in_ready = 0.
- Simultaneous events: when out_ready = 1 and S2 is full, S2 drains, S1 advances and a new input is accepted at the same edge, with no bubble.
- Output ordering equals input ordering. Beats are never dropped or duplicated.
- out_* hold stable while out_valid = 1 and out_ready = 0.

## Test plan
- Basic normalize: in_data = 64'h0000_0000_0001_0000, in_lz = 47, in_exp = 100 -> after 2 cycles out_data = 64'h8000_0000_0000_0000, out_exp = 53, out_zero = 0, out_uflow = 0.
- Underflow: in_data = 64'h1, in_lz = 63, in_exp = 10 -> out_data = 64'h400, out_exp = 0, out_uflow = 1.
- Zero and no-shift:
  - in_data = 0, in_lz = 0, in_exp = 500 -> out_data = 0, out_exp = 0, out_zero = 1.
  - in_data = 64'hC000_0000_0000_0000, in_lz = 0, in_exp = 7 -> data unchanged, out_exp = 7.
- Backpressure: stream 6 beats with out_ready low for cycles 2-6 -> in_ready drops after 2 accepted beats; all 6 beats emerge in order with exact values; outputs stable during the stall.
- Full-rate streaming: 100 random beats, each with in_lz = true leading-zero count and in_exp random, out_ready = 1 -> one result per cycle after the 2-cycle fill; every result matches a reference model.
- Reset mid-stream: assert rst_n low for 1 cycle with both stages full -> next cycle out_valid = 0, all outputs 0, in_ready = 1; the next accepted beat appears normally 2 cycles later.
